// File: rtl/traffic_ctrl_timed.sv
// Highway/farm-road traffic light controller with internal dwell timing and all-red clearance.
// Define TRAFFIC_FLASH_EN to add the flash input and the flashing-yellow FLASH state.
module traffic_ctrl_timed #(
    parameter int SHORT_CYCLES  = 3,
    parameter int LONG_CYCLES   = 8,
    parameter int ALLRED_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car,
`ifdef TRAFFIC_FLASH_EN
    input  logic       flash,
`endif
    output logic [2:0] state,
    output logic [2:0] Hlights,
    output logic [2:0] Flights,
    output logic       sto,
    output logic       lto
);

    // state | meaning
    // HG    | highway green, farm red
    // HY    | highway yellow, farm red
    // HR    | all red, clearing toward farm road
    // FG    | farm green, highway red
    // FY    | farm yellow, highway red
    // FR    | all red, clearing toward highway
    // FLASH | flashing highway yellow (TRAFFIC_FLASH_EN only)
    typedef enum logic [2:0] {
        HG    = 3'b000,
        HY    = 3'b001,
        FLASH = 3'b010,
        HR    = 3'b011,
        FY    = 3'b100,
        FR    = 3'b101,
        FG    = 3'b110
    } state_t;

    localparam logic [CNT_W-1:0] SHORT_M1  = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    // State register is plain logic so an illegal code can be held and decoded.
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ar;
`ifdef TRAFFIC_FLASH_EN
    logic             phase_q;
    logic             phase_d;
`endif

    assign sto   = (cnt_q >= SHORT_M1);
    assign lto   = (cnt_q >= LONG_M1);
    assign ar    = (cnt_q >= ALLRED_M1);
    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HG;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TRAFFIC_FLASH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            HG:      if (car && lto)          state_d = HY;
            HY:      if (sto)                 state_d = HR;
            HR:      if (ar)                  state_d = FG;
            FG:      if (lto || (sto && !car)) state_d = FY;
            FY:      if (sto)                 state_d = FR;
            FR:      if (ar)                  state_d = HG;
`ifdef TRAFFIC_FLASH_EN
            FLASH:   if (!flash)              state_d = FR;
`endif
            default:                          state_d = HG;
        endcase
`ifdef TRAFFIC_FLASH_EN
        if (flash && (state_q != FLASH)) begin
            state_d = FLASH;
        end
`endif
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
`ifdef TRAFFIC_FLASH_EN
        phase_d = phase_q;
        if ((state_d == FLASH) && (state_q != FLASH)) begin
            phase_d = 1'b1;
        end else if ((state_d == FLASH) && (state_q == FLASH) && sto) begin
            // Each flash phase lasts SHORT_CYCLES clocks; restart the count on toggle.
            phase_d = ~phase_q;
            cnt_d   = '0;
        end
`endif
    end

    always_comb begin
        Hlights = LAMP_RED;
        Flights = LAMP_RED;
        case (state_q)
            HG:    Hlights = LAMP_GREEN;
            HY:    Hlights = LAMP_YELLOW;
            FG:    Flights = LAMP_GREEN;
            FY:    Flights = LAMP_YELLOW;
`ifdef TRAFFIC_FLASH_EN
            FLASH: begin
                Hlights = phase_q ? LAMP_YELLOW : LAMP_OFF;
                Flights = phase_q ? LAMP_RED    : LAMP_OFF;
            end
`endif
            default: begin
                Hlights = LAMP_RED;
                Flights = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Directed self-checking bench for traffic_ctrl_timed with default parameters.
// Define TRAFFIC_FLASH_EN to also exercise the flashing mode.
module tb_traffic_ctrl_timed;

    logic       clk = 1'b0;
    logic       reset;
    logic       car;
    logic [2:0] state;
    logic [2:0] Hlights;
    logic [2:0] Flights;
    logic       sto;
    logic       lto;
`ifdef TRAFFIC_FLASH_EN
    logic       flash;
`endif

    int total = 0;
    int bad   = 0;

    traffic_ctrl_timed dut (
        .clk     (clk),
        .reset   (reset),
        .car     (car),
`ifdef TRAFFIC_FLASH_EN
        .flash   (flash),
`endif
        .state   (state),
        .Hlights (Hlights),
        .Flights (Flights),
        .sto     (sto),
        .lto     (lto)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one time unit after a falling-edge release: first clock, cnt=0.
    task automatic do_reset(input logic car_v);
        reset = 1'b0;
        car   = car_v;
`ifdef TRAFFIC_FLASH_EN
        flash = 1'b0;
`endif
        #12;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        car   = 1'b0;
`ifdef TRAFFIC_FLASH_EN
        flash = 1'b0;
`endif
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (state !== 3'b000) begin bad++; $display("FAIL reset_state got=%b exp=000", state); end
        total++;
        if (Hlights !== 3'b010) begin bad++; $display("FAIL reset_H got=%b exp=010", Hlights); end
        total++;
        if (Flights !== 3'b100) begin bad++; $display("FAIL reset_F got=%b exp=100", Flights); end
        total++;
        if (sto !== 1'b0 || lto !== 1'b0) begin
            bad++; $display("FAIL reset_timeouts got sto=%b lto=%b exp 0/0", sto, lto);
        end
        total++;
        if (dut.cnt_q !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt_q); end
    endtask

    task automatic test_idle;
        logic exp_lto;
        do_reset(1'b0);
        for (int i = 1; i <= 20; i++) begin
            exp_lto = (i >= 8);
            total++;
            if (state !== 3'b000 || lto !== exp_lto || Hlights !== 3'b010 || Flights !== 3'b100) begin
                bad++;
                $display("FAIL idle clk=%0d state=%b(exp 000) lto=%b(exp %b) H=%b(exp 010) F=%b(exp 100)",
                         i, state, lto, exp_lto, Hlights, Flights);
            end
            tick();
        end
    endtask

    task automatic test_full_cycle;
        logic [2:0] seg_s [6] = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b100, 3'b101};
        logic [2:0] seg_h [6] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
        logic [2:0] seg_f [6] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};
        int         seg_d [6] = '{8, 3, 2, 8, 3, 2};
        int         period;
        do_reset(1'b1);
        period = 0;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < seg_d[s]; c++) begin
                total++;
                if (state !== seg_s[s] || Hlights !== seg_h[s] || Flights !== seg_f[s]) begin
                    bad++;
                    $display("FAIL full_cycle clk=%0d state=%b/%b H=%b/%b F=%b/%b (got/exp)",
                             period + 1, state, seg_s[s], Hlights, seg_h[s], Flights, seg_f[s]);
                end
                period++;
                tick();
            end
        end
        total++;
        if (state !== 3'b000 || period != 26) begin
            bad++; $display("FAIL full_cycle_wrap state=%b exp=000 period=%0d exp=26", state, period);
        end
    endtask

    task automatic test_fg_car_drop;
        do_reset(1'b1);
        repeat (13) tick();
        for (int c = 1; c <= 3; c++) begin
            total++;
            if (state !== 3'b110 || Flights !== 3'b010) begin
                bad++; $display("FAIL fg_drop clk=%0d state=%b exp=110 F=%b exp=010", c, state, Flights);
            end
            if (c == 1) begin
                tick();
                car = 1'b0;
            end else begin
                tick();
            end
        end
        total++;
        if (state !== 3'b100 || Flights !== 3'b001) begin
            bad++; $display("FAIL fg_drop_exit state=%b exp=100 F=%b exp=001", state, Flights);
        end
    endtask

    task automatic test_car_pulse;
        do_reset(1'b0);
        for (int i = 1; i <= 20; i++) begin
            car = (i == 3);
            total++;
            if (state !== 3'b000) begin
                bad++; $display("FAIL car_pulse clk=%0d state=%b exp=000", i, state);
            end
            tick();
        end
        car = 1'b0;
    endtask

    task automatic test_illegal;
        do_reset(1'b1);
        repeat (3) tick();
        #3;
        force dut.state_q = 3'b111;
        #1;
        total++;
        if (state !== 3'b111 || Hlights !== 3'b100 || Flights !== 3'b100) begin
            bad++; $display("FAIL illegal_lamps state=%b H=%b F=%b exp 111/100/100", state, Hlights, Flights);
        end
        release dut.state_q;
        tick();
        total++;
        if (state !== 3'b000 || dut.cnt_q !== 4'd0 || Hlights !== 3'b010) begin
            bad++; $display("FAIL illegal_recover state=%b exp=000 cnt=%0d exp=0 H=%b exp=010",
                            state, dut.cnt_q, Hlights);
        end
    endtask

    task automatic test_reset_mid_fy;
        do_reset(1'b1);
        repeat (21) tick();
        total++;
        if (state !== 3'b100) begin bad++; $display("FAIL mid_fy_reach state=%b exp=100", state); end
        tick();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (state !== 3'b000 || Hlights !== 3'b010 || Flights !== 3'b100 ||
            sto !== 1'b0 || lto !== 1'b0 || dut.cnt_q !== 4'd0) begin
            bad++;
            $display("FAIL mid_fy_reset state=%b H=%b F=%b sto=%b lto=%b cnt=%0d exp 000/010/100/0/0/0",
                     state, Hlights, Flights, sto, lto, dut.cnt_q);
        end
        #2;
        reset = 1'b1;
        tick();
        total++;
        if (state !== 3'b000 || dut.cnt_q !== 4'd1) begin
            bad++; $display("FAIL mid_fy_restart state=%b exp=000 cnt=%0d exp=1", state, dut.cnt_q);
        end
    endtask

`ifdef TRAFFIC_FLASH_EN
    task automatic test_flash;
        logic [2:0] exp_h;
        logic [2:0] exp_f;
        do_reset(1'b1);
        repeat (8) tick();
        total++;
        if (state !== 3'b001) begin bad++; $display("FAIL flash_reach_hy state=%b exp=001", state); end
        flash = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            exp_h = (((k / 3) % 2) == 0) ? 3'b001 : 3'b000;
            exp_f = (((k / 3) % 2) == 0) ? 3'b100 : 3'b000;
            total++;
            if (state !== 3'b010 || Hlights !== exp_h || Flights !== exp_f) begin
                bad++;
                $display("FAIL flash clk=%0d state=%b exp=010 H=%b exp=%b F=%b exp=%b",
                         k, state, Hlights, exp_h, Flights, exp_f);
            end
            if (k == 8) flash = 1'b0;
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            total++;
            if (state !== 3'b101) begin bad++; $display("FAIL flash_exit_fr clk=%0d state=%b exp=101", c, state); end
            tick();
        end
        total++;
        if (state !== 3'b000) begin bad++; $display("FAIL flash_exit_hg state=%b exp=000", state); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_full_cycle();
        test_fg_car_drop();
        test_car_pulse();
        test_illegal();
        test_reset_mid_fy();
`ifdef TRAFFIC_FLASH_EN
        test_flash();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
